// File: rtl/button_debouncer_if.sv
// Button conditioning bus: one raw button in, clean level and event pulses out.
// The source side (button / test driver) uses the master modport; the
// debouncer uses the slave modport.
//
// Handshake: there is no valid/ready pair. btn_in is a free-running
// asynchronous level. btn_press and btn_release are single-cycle strobes that
// a consumer must take on the cycle they are high; they never backpressure and
// are never high together. tick is a one-cycle strobe at the sample rate.
// fsm_state mirrors the debouncer FSM for observation only.
interface button_debouncer_if;
    logic       btn_in;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       tick;
    logic [1:0] fsm_state;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  tick,
        input  fsm_state
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output tick,
        output fsm_state
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer with optional auto-repeat.
// The raw input is synchronised, sampled on a slow tick into a shift register,
// and a three-state FSM changes the debounced level only once STABLE_SAMPLES
// consecutive samples agree. Press/release strobes are registered.
// Constraints: CLK_FREQ/DEBOUNCE_FREQ must be an integer >= 2,
// STABLE_SAMPLES in 2..16, REPEAT_PERIOD >= 1 whenever REPEAT_DELAY > 0.
module button_debouncer #(
    parameter int CLK_FREQ       = 50000000,
    parameter int DEBOUNCE_FREQ  = 1000000,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_PERIOD  = 100
) (
    input logic               clk,
    input logic               rst_n,
    button_debouncer_if.slave bus
);

    // Tick divider sizing: counter runs 0..DIV-1.
    localparam int DIV   = CLK_FREQ / DEBOUNCE_FREQ;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    // Repeat counter sizing: large enough to hold the larger of the two
    // intervals; it saturates at all ones instead of wrapping.
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             ((REPEAT_DELAY > 0) ? REPEAT_DELAY : 1) :
                             ((REPEAT_PERIOD > 0) ? REPEAT_PERIOD : 1);
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_SAT    = '1;
    localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);
    localparam bit               REP_ON     = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    // Synchroniser, tick divider and sample history.
    logic                      sync_a;
    logic                      btn_s;
    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick_int;
    logic [STABLE_SAMPLES-1:0] samples;
    logic [STABLE_SAMPLES-1:0] samples_next;
    logic                      all1;
    logic                      all0;

    // FSM state, repeat counter and registered strobes.
    state_t           state;
    state_t           state_next;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_next;
    logic [REP_W-1:0] rep_inc;
    logic             press;
    logic             press_next;
    logic             release_r;
    logic             release_next;

    // Two-flop synchroniser on the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_a <= bus.btn_in;
            btn_s  <= sync_a;
        end
    end

    // Free-running sample divider; tick marks the last count of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_int) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    assign tick_int = (tick_cnt == CNT_MAX);

    // The qualification test looks at the history including the sample taken
    // on this very tick, so a change is recognised on the Nth agreeing tick.
    assign samples_next = {samples[STABLE_SAMPLES-2:0], btn_s};
    assign all1         = &samples_next;
    assign all0         = ~|samples_next;

    // Shift one synchronised sample in per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples <= '0;
        end else if (tick_int) begin
            samples <= samples_next;
        end
    end

    // Saturating increment so a long hold can never wrap into a false repeat.
    assign rep_inc = (rep_cnt == REP_SAT) ? rep_cnt : rep_cnt + REP_W'(1);

    // FSM state, repeat counter and event strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rep_cnt   <= '0;
            press     <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state     <= state_next;
            rep_cnt   <= rep_cnt_next;
            press     <= press_next;
            release_r <= release_next;
        end
    end

    // Next-state logic: qualified release always wins over a repeat that
    // falls due on the same tick; repeat counting only advances on ticks.
    always_comb begin
        state_next   = state;
        rep_cnt_next = rep_cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        unique case (state)
            IDLE: begin
                rep_cnt_next = '0;
                if (tick_int && all1) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (tick_int) begin
                    if (all0) begin
                        state_next   = IDLE;
                        release_next = 1'b1;
                        rep_cnt_next = '0;
                    end else if (REP_ON) begin
                        if (rep_inc == REP_DELAY) begin
                            state_next   = REPEAT;
                            press_next   = 1'b1;
                            rep_cnt_next = '0;
                        end else begin
                            rep_cnt_next = rep_inc;
                        end
                    end
                end
            end
            REPEAT: begin
                if (tick_int) begin
                    if (all0) begin
                        state_next   = IDLE;
                        release_next = 1'b1;
                        rep_cnt_next = '0;
                    end else if (rep_inc == REP_PERIOD) begin
                        press_next   = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_inc;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                rep_cnt_next = '0;
            end
        endcase
    end

    assign bus.btn_level   = (state != IDLE);
    assign bus.btn_press   = press;
    assign bus.btn_release = release_r;
    assign bus.tick        = tick_int;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: a segment table for the default
// instance plus hand-written auto-repeat and reset-while-held sequences.
module tb_button_debouncer;

  logic clk;
  logic rst_n;

  button_debouncer_if bus0 ();
  button_debouncer_if bus1 ();

  button_debouncer dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  button_debouncer #(
    .REPEAT_DELAY  (5),
    .REPEAT_PERIOD (2)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- pulse monitors ----------------
  int   press_total0 = 0;
  int   rel_total0   = 0;
  int   width_err    = 0;
  int   overlap_err  = 0;
  int   alt_err      = 0;
  int   tick_err     = 0;
  int   n_ticks      = 0;
  int   cyc          = 0;
  int   last_tick    = -1;
  int   last_evt     = 0;
  logic pp0 = 1'b0, pr0 = 1'b0, pp1 = 1'b0, pr1 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pp0 = 1'b0; pr0 = 1'b0; pp1 = 1'b0; pr1 = 1'b0;
      last_evt  = 0;
      last_tick = -1;
      n_ticks   = 0;
    end else begin
      if ((bus0.btn_press && pp0) || (bus0.btn_release && pr0) ||
          (bus1.btn_press && pp1) || (bus1.btn_release && pr1)) width_err++;
      if ((bus0.btn_press && bus0.btn_release) || (bus1.btn_press && bus1.btn_release)) overlap_err++;
      if (bus0.btn_press) begin
        press_total0++;
        if (last_evt == 1) alt_err++;
        last_evt = 1;
      end
      if (bus0.btn_release) begin
        rel_total0++;
        if (last_evt != 1) alt_err++;
        last_evt = 2;
      end
      if (bus0.tick) begin
        n_ticks++;
        if (last_tick >= 0 && (cyc - last_tick) != 50) tick_err++;
        last_tick = cyc;
      end
      pp0 = bus0.btn_press; pr0 = bus0.btn_release;
      pp1 = bus1.btn_press; pr1 = bus1.btn_release;
    end
  end

  // ---------------- segment table ----------------
  typedef struct {
    logic btn;
    int   cycles;
    int   exp_press;
    int   exp_release;
    logic exp_level;
    logic align;
    int   lat_lo;
    int   lat_hi;
  } row_t;

  localparam int NROWS = 11;
  row_t tbl [NROWS];

  // ---------------- driver tasks ----------------
  task automatic wait_tick0(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus0.tick && w < 100) begin
      @(negedge clk);
      w++;
    end
    check(name, bus0.tick, 1);
  endtask

  task automatic run_row(input int r);
    int np, nr, lat;
    if (tbl[r].align) wait_tick0($sformatf("row%0d_align", r));
    bus0.btn_in = tbl[r].btn;
    np = 0; nr = 0; lat = 0;
    for (int i = 0; i < tbl[r].cycles; i++) begin
      @(negedge clk);
      if (bus0.btn_press) np++;
      if (bus0.btn_release) nr++;
      if ((bus0.btn_press || bus0.btn_release) && lat == 0) lat = i + 1;
    end
    check($sformatf("row%0d_press", r), np, tbl[r].exp_press);
    check($sformatf("row%0d_release", r), nr, tbl[r].exp_release);
    check($sformatf("row%0d_level", r), int'(bus0.btn_level), int'(tbl[r].exp_level));
    if (tbl[r].lat_hi > 0) check_range($sformatf("row%0d_latency", r), lat, tbl[r].lat_lo, tbl[r].lat_hi);
  endtask

  // ---------------- scoreboard for auto-repeat ----------------
  logic [15:0] exp_q[$];

  initial begin
    int p0, tick_idx, n_press1, extra, rel_seen, done, lat, pt0, rt0;

    // idle, bounce press, bounce release
    tbl[0]  = '{1'b0, 1000, 0, 0, 1'b0, 1'b0, 0,   0};
    tbl[1]  = '{1'b1, 3,    0, 0, 1'b0, 1'b1, 0,   0};
    tbl[2]  = '{1'b0, 6,    0, 0, 1'b0, 1'b0, 0,   0};
    tbl[3]  = '{1'b1, 5,    0, 0, 1'b0, 1'b0, 0,   0};
    tbl[4]  = '{1'b0, 10,   0, 0, 1'b0, 1'b0, 0,   0};
    tbl[5]  = '{1'b1, 400,  1, 0, 1'b1, 1'b0, 153, 203};
    tbl[6]  = '{1'b0, 3,    0, 0, 1'b1, 1'b1, 0,   0};
    tbl[7]  = '{1'b1, 6,    0, 0, 1'b1, 1'b0, 0,   0};
    tbl[8]  = '{1'b0, 5,    0, 0, 1'b1, 1'b0, 0,   0};
    tbl[9]  = '{1'b1, 10,   0, 0, 1'b1, 1'b0, 0,   0};
    tbl[10] = '{1'b0, 400,  0, 1, 1'b0, 1'b0, 153, 203};

    // reset
    rst_n = 1'b1;
    bus0.btn_in = 1'b0;
    bus1.btn_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level", int'(bus0.btn_level), 0);
    check("reset_press", int'(bus0.btn_press), 0);
    check("reset_release", int'(bus0.btn_release), 0);
    check("reset_tick", int'(bus0.tick), 0);
    check("reset_state", int'(bus0.fsm_state), 0);
    rst_n = 1'b1;

    // idle for 1000 cycles, then bounce bursts
    run_row(0);
    check("tick_count_1000", n_ticks, 20);
    for (int r = 1; r < NROWS; r++) run_row(r);

    // ten clean press/release cycles
    pt0 = press_total0;
    rt0 = rel_total0;
    for (int k = 0; k < 10; k++) begin
      bus0.btn_in = 1'b1;
      repeat (200) @(negedge clk);
      bus0.btn_in = 1'b0;
      repeat (200) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    check("clean_presses", press_total0 - pt0, 10);
    check("clean_releases", rel_total0 - rt0, 10);
    check("clean_level", int'(bus0.btn_level), 0);

    // auto-repeat: delay 5, period 2, release qualifies on a repeat tick
    p0 = -1; tick_idx = 0; n_press1 = 0; extra = 0; rel_seen = 0; done = 0;
    bus1.btn_in = 1'b1;
    for (int c = 0; c < 4000 && done == 0; c++) begin
      @(negedge clk);
      if (bus1.tick) tick_idx++;
      if (bus1.btn_press) begin
        n_press1++;
        if (p0 < 0) begin
          p0 = tick_idx;
          for (int k = 5; k <= 29; k += 2) exp_q.push_back(16'(p0 + k));
        end else if (exp_q.size() == 0) begin
          extra++;
        end else begin
          check("repeat_tick", tick_idx, int'(exp_q.pop_front()));
        end
      end
      if (bus1.btn_release) begin
        rel_seen++;
        check("release_on_repeat_tick", tick_idx, p0 + 31);
      end
      if (p0 >= 0 && bus1.tick && tick_idx == p0 + 27) bus1.btn_in = 1'b0;
      if (rel_seen > 0 && tick_idx >= p0 + 40) done = 1;
    end
    check("repeat_first_press_seen", int'(p0 >= 0), 1);
    check("repeat_press_count", n_press1, 14);
    check("repeat_queue_empty", exp_q.size(), 0);
    check("repeat_extra_press", extra, 0);
    check("repeat_release_count", rel_seen, 1);
    check("repeat_final_level", int'(bus1.btn_level), 0);

    // reset while held
    bus0.btn_in = 1'b1;
    for (int i = 0; i < 300 && !bus0.btn_level; i++) @(negedge clk);
    check("held_level_before_reset", int'(bus0.btn_level), 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_level", int'(bus0.btn_level), 0);
    check("rst_async_press", int'(bus0.btn_press), 0);
    check("rst_async_release", int'(bus0.btn_release), 0);
    check("rst_async_tick", int'(bus0.tick), 0);
    #99 rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 400 && lat == 0; i++) begin
      @(negedge clk);
      if (bus0.btn_press) lat = i + 1;
    end
    check_range("rst_repress_latency", lat, 153, 203);
    check("rst_repress_level", int'(bus0.btn_level), 1);

    // global pulse properties
    check("pulse_width_errors", width_err, 0);
    check("press_release_overlap", overlap_err, 0);
    check("press_release_alternation", alt_err, 0);
    check("tick_period_errors", tick_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
